// File: rtl/apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB master bridge.
// Optional feature macro used by the bridge: APB_BRIDGE_TIMEOUT_EN.
package apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } bridge_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not
    function automatic logic is_active_trans(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/apb_bridge_timeout_cnt.sv
// ACCESS wait-state counter for the AHB-APB bridge.
// Cleared on the SETUP->ACCESS step, counts PREADY-low ACCESS cycles and
// flags when the final allowed wait cycle has been reached.
module apb_bridge_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign hit_o = (cnt_q == CNT_LAST);

    // Next count: clear, saturating increment at the last value, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && !hit_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_apb_master_bridge.sv
// AHB-Lite slave to APB master bridge (single clock PCLK).
// Each accepted AHB transfer becomes one APB SETUP/ACCESS transfer; PREADY
// wait states are honoured and PSLVERR maps to a two-cycle AHB ERROR.
// Optional feature macro: APB_BRIDGE_TIMEOUT_EN (ACCESS wait timeout).
module ahb_apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  APB_TIMEOUT
);

    bridge_state_t         state_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]           pwdata_q;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic [31:0]           hrdata_q;
    logic                  apb_timeout_q;

    logic accept_s;
    logic timeout_hit_s;
    logic unused_s;

    // Transfer size is irrelevant (all word) and upper address bits are not decoded
    assign unused_s = ^{HSIZE, HADDR[31:ADDR_WIDTH]};

    assign accept_s = HSEL & HREADY & is_active_trans(HTRANS);

`ifdef APB_BRIDGE_TIMEOUT_EN
    logic cnt_hit_s;

    apb_bridge_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i   (PCLK),
        .rst_n_i (PRESETn),
        .clr_i   (state_q == SETUP),
        .inc_i   ((state_q == ACCESS) && !PREADY),
        .hit_o   (cnt_hit_s)
    );

    assign timeout_hit_s = cnt_hit_s & ~PREADY;
    assign APB_TIMEOUT   = apb_timeout_q;
`else
    logic [31:0] unused_timeout_s;
    logic        unused_pulse_s;

    assign unused_timeout_s = TIMEOUT_CYCLES;
    assign unused_pulse_s   = apb_timeout_q;
    assign timeout_hit_s    = 1'b0;
    assign APB_TIMEOUT      = 1'b0;
`endif

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

    // Bridge FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= {ADDR_WIDTH{1'b0}};
            pwdata_q      <= 32'h0000_0000;
            hreadyout_q   <= 1'b1;
            hresp_q       <= HRESP_OKAY;
            hrdata_q      <= 32'h0000_0000;
            apb_timeout_q <= 1'b0;
        end else begin
            apb_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    hresp_q <= HRESP_OKAY;
                    if (accept_s) begin
                        paddr_q     <= HADDR[ADDR_WIDTH-1:0];
                        pwrite_q    <= HWRITE;
                        hreadyout_q <= 1'b0;
                        if (HWRITE) begin
                            state_q <= WDATA;
                        end else begin
                            psel_q  <= 1'b1;
                            state_q <= SETUP;
                        end
                    end else begin
                        hreadyout_q <= 1'b1;
                    end
                end
                WDATA: begin
                    // HWDATA is valid in the first data-phase cycle
                    pwdata_q <= HWDATA;
                    psel_q   <= 1'b1;
                    state_q  <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (!pwrite_q) begin
                            hrdata_q <= PRDATA;
                        end
                        if (PSLVERR) begin
                            hresp_q <= HRESP_ERROR;
                            state_q <= ERR1;
                        end else begin
                            hreadyout_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else if (timeout_hit_s) begin
                        // Abort: HRDATA keeps its previous value
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        apb_timeout_q <= 1'b1;
                        hresp_q       <= HRESP_ERROR;
                        state_q       <= ERR1;
                    end
                end
                ERR1: begin
                    hreadyout_q <= 1'b1;
                    state_q     <= ERR2;
                end
                ERR2: begin
                    // Second ERROR cycle: nothing is accepted here
                    hresp_q <= HRESP_OKAY;
                    state_q <= IDLE;
                end
                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_master_bridge.sv
// Self-checking bench for ahb_apb_master_bridge: AHB driver with an
// expected-response queue, APB slave model and APB-side monitor with its
// own expected-transfer queue.
module tb_ahb_apb_master_bridge;

    localparam int AW     = 12;
    localparam int TO_CYC = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic          APB_TIMEOUT;

    always #5 PCLK = ~PCLK;

    ahb_apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .APB_TIMEOUT (APB_TIMEOUT)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          pulses;
    } ahb_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   wdata;
        int            wait_n;
    } apb_exp_t;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'h0;

    // slave model configuration
    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic        slv_err_early = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          acc_n = 0;

    // monitor state
    int            mon_psel_n = 0;
    int            mon_pen_n = 0;
    int            mon_gap = 0;
    int            last_gap = 0;
    logic          mon_stable = 1'b1;
    logic          mon_post = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic [31:0]   cap_wdata = 32'h0;
    logic          cap_wr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // APB slave: responds on each negedge during ACCESS
    initial begin
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'hDEAD_BEEF;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                PREADY  = (acc_n >= slv_wait);
                PSLVERR = PREADY ? slv_err : slv_err_early;
                PRDATA  = PREADY ? slv_rdata : 32'hDEAD_BEEF;
                acc_n   = acc_n + 1;
            end else begin
                acc_n   = 0;
                PREADY  = 1'b1;
                PSLVERR = 1'b0;
                PRDATA  = 32'hDEAD_BEEF;
            end
        end
    end

    // APB monitor: checks each completed APB transfer against apb_q
    initial begin
        apb_exp_t e;
        forever begin
            @(negedge PCLK);
            #1;
            if (!PRESETn) begin
                mon_psel_n = 0;
                mon_pen_n  = 0;
                mon_post   = 1'b0;
            end else begin
                if (mon_post) begin
                    chk("hold_paddr", PADDR, cap_addr);
                    chk("hold_pwdata", PWDATA, cap_wdata);
                    mon_post = 1'b0;
                end
                if (PSEL) begin
                    if (mon_psel_n == 0) begin
                        last_gap   = mon_gap;
                        cap_addr   = PADDR;
                        cap_wdata  = PWDATA;
                        cap_wr     = PWRITE;
                        mon_stable = 1'b1;
                        chk("setup_penable", PENABLE, 1'b0);
                    end else if (PADDR !== cap_addr || PWDATA !== cap_wdata || PWRITE !== cap_wr) begin
                        mon_stable = 1'b0;
                    end
                    mon_psel_n++;
                    if (PENABLE) mon_pen_n++;
                    if (PENABLE && PREADY) begin
                        if (apb_q.size() == 0) begin
                            chk("apb_unexpected", 32'd0, 32'd1);
                        end else begin
                            e = apb_q.pop_front();
                            chk("paddr", PADDR, e.addr);
                            chk("pwrite", PWRITE, e.wr);
                            if (e.wr) chk("pwdata", PWDATA, e.wdata);
                            chk("apb_stable", mon_stable, 1'b1);
                            chk("psel_cycles", mon_psel_n, e.wait_n + 2);
                            chk("penable_cycles", mon_pen_n, e.wait_n + 1);
                        end
                        mon_post   = 1'b1;
                        mon_psel_n = 0;
                        mon_pen_n  = 0;
                        mon_gap    = 0;
                    end
                end else begin
                    mon_gap++;
                    mon_psel_n = 0;
                    mon_pen_n  = 0;
                end
            end
        end
    end

    // One AHB transfer; called at a negedge where the bridge can accept
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wt, input logic err, input logic early,
                           input logic [31:0] rdata, input logic to);
        ahb_exp_t a;
        ahb_exp_t e;
        apb_exp_t p;
        int       lat;
        int       nresp;
        int       npulse;
        logic     done;
        slv_wait      = to ? 100000 : wt;
        slv_err       = err;
        slv_err_early = early;
        slv_rdata     = rdata;
        if (!wr && !to) last_rdata = rdata;
        a.rdata  = last_rdata;
        a.err    = err | to;
        a.lat    = (wr ? 1 : 0) + 1 + (to ? TO_CYC : (1 + wt)) + ((err || to) ? 2 : 1);
        a.pulses = to ? 1 : 0;
        ahb_q.push_back(a);
        if (!to) begin
            p.addr   = addr[AW-1:0];
            p.wr     = wr;
            p.wdata  = wdata;
            p.wait_n = wt;
            apb_q.push_back(p);
        end
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        @(posedge PCLK);
        @(negedge PCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
        HWDATA = wdata;
        lat    = 0;
        nresp  = 0;
        npulse = 0;
        done   = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (i > 0) @(negedge PCLK);
            lat++;
            if (HRESP) nresp++;
            if (APB_TIMEOUT) npulse++;
            if (HREADYOUT) done = 1'b1;
        end
        if (!done) chk("ahb_hang", 32'd0, 32'd1);
        e = ahb_q.pop_front();
        chk("latency", lat, e.lat);
        chk("hresp_cycles", nresp, e.err ? 2 : 0);
        chk("hresp_final", HRESP, e.err);
        chk("hrdata", HRDATA, e.rdata);
        chk("timeout_pulses", npulse, e.pulses);
    endtask

    // Drive a non-transfer for one cycle and verify nothing starts
    task automatic no_accept(input string tag, input logic hsel, input logic [1:0] htrans, input logic hready);
        int psel_seen;
        int nrdy;
        HSEL   = hsel;
        HTRANS = htrans;
        HREADY = hready;
        HADDR  = 32'h0000_0ABC;
        HWRITE = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HREADY = 1'b1;
        psel_seen = 0;
        nrdy = 0;
        for (int i = 0; i < 3; i++) begin
            if (PSEL) psel_seen++;
            if (!HREADYOUT || HRESP) nrdy++;
            @(negedge PCLK);
        end
        chk({tag, "_psel"}, psel_seen, 0);
        chk({tag, "_okay"}, nrdy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int psel_seen;
        PRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = 32'h0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'b010;
        HWDATA  = 32'h0;
        HREADY  = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp", HRESP, 1'b0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_timeout", APB_TIMEOUT, 1'b0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // zero-wait read and write
        do_xfer(1'b0, 32'h0000_0004, 32'h0, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        do_xfer(1'b1, 32'h0000_0000, 32'h0000_1234, 0, 1'b0, 1'b0, 32'h0, 1'b0);

        // one wait state then PSLVERR
        do_xfer(1'b1, 32'h0000_0000, 32'hA5A5_0001, 1, 1'b1, 1'b0, 32'h0, 1'b0);

        // a transfer offered during the second ERROR cycle is ignored
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 32'h0000_00FC;
        HWRITE = 1'b0;
        @(negedge PCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        psel_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (PSEL) psel_seen++;
            @(negedge PCLK);
        end
        chk("err2_no_accept", psel_seen, 0);

        // back-to-back read then write, upper address bits dropped
        do_xfer(1'b0, 32'h4000_0010, 32'h0, 0, 1'b0, 1'b0, 32'h1357_9BDF, 1'b0);
        do_xfer(1'b1, 32'h0000_0008, 32'h0000_0020, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("b2b_gap_rw", last_gap, 2);

        // wait states, PSLVERR high only while PREADY low must be ignored
        do_xfer(1'b0, 32'h0000_0FFC, 32'h0, 2, 1'b0, 1'b1, 32'h8000_0001, 1'b0);
        do_xfer(1'b0, 32'h0000_0100, 32'h0, 0, 1'b0, 1'b0, 32'h0F0F_0F0F, 1'b0);
        chk("b2b_gap_rr", last_gap, 1);
        do_xfer(1'b1, 32'h0000_0200, 32'hCAFE_0003, 3, 1'b0, 1'b0, 32'h0, 1'b0);
        // read with error still updates HRDATA
        do_xfer(1'b0, 32'h0000_0300, 32'h0, 0, 1'b1, 1'b0, 32'h5555_AAAA, 1'b0);
        @(negedge PCLK);

        // non-transfer cycles
        no_accept("hsel0", 1'b0, 2'b10, 1'b1);
        no_accept("busy", 1'b1, 2'b01, 1'b1);
        no_accept("idle", 1'b1, 2'b00, 1'b1);
        no_accept("hready0", 1'b1, 2'b10, 1'b0);

        // reset in the middle of ACCESS
        slv_wait  = 5;
        slv_err   = 1'b0;
        slv_rdata = 32'h0BAD_0BAD;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 32'h0000_0020;
        HWRITE = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        for (int i = 0; i < 10 && !PENABLE; i++) @(negedge PCLK);
        chk("rst_pre_penable", PENABLE, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        chk("midrst_psel", PSEL, 1'b0);
        chk("midrst_penable", PENABLE, 1'b0);
        chk("midrst_hreadyout", HREADYOUT, 1'b1);
        chk("midrst_hrdata", HRDATA, 32'h0);
        last_rdata = 32'h0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        do_xfer(1'b1, 32'h0000_0040, 32'h1111_2222, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        do_xfer(1'b0, 32'h0000_0030, 32'h0, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);

`ifdef APB_BRIDGE_TIMEOUT_EN
        // PREADY stuck low: abort after TO_CYC ACCESS cycles, HRDATA unchanged
        do_xfer(1'b0, 32'h0000_0044, 32'h0, 0, 1'b0, 1'b0, 32'h7777_7777, 1'b1);
        @(negedge PCLK);
        do_xfer(1'b0, 32'h0000_0048, 32'h0, 0, 1'b0, 1'b0, 32'h2468_ACE0, 1'b0);
`endif

        repeat (3) @(negedge PCLK);
        chk("apb_q_empty", apb_q.size(), 0);
        chk("ahb_q_empty", ahb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
